// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for the Execute stage: MUL, MLA and UMULL-class
// operations over WIDTH cycles, with N/Z flag generation and a combinational stall.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             AccE,
    input  logic             LongE,
    input  logic             SetFlagsE,
    input  logic             FlushE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [WIDTH-1:0] SrcCE,
    output logic             BusyE,
    output logic             DoneM,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [3:0]       MulFlags,
    output logic [1:0]       MulFlagWrite
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               long_q, long_d;
    logic               setf_q, setf_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic [1:0]         fw_q, fw_d;

    logic               accept;
    logic               last;
    logic               finish;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] p_sum;

    always_comb begin
        accept = StartE && !FlushE && (state_q != RUN);
        last   = (cnt_q == CW'(WIDTH - 1));
        finish = (state_q == RUN) && !FlushE && last;
        addend = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
        p_sum  = p_q + addend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN: begin
                if (FlushE)    state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers only move on a completed iteration sequence, so the previous
    // product stays visible while a back-to-back operation is being accepted.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        long_d  = long_q;
        setf_d  = setf_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        done_d  = finish;
        fw_d    = (finish && setf_q) ? 2'b10 : 2'b00;

        if (accept) begin
            a_d    = SrcAE;
            b_d    = SrcBE;
            long_d = LongE;
            setf_d = SetFlagsE;
            p_d    = AccE ? {{WIDTH{1'b0}}, SrcCE} : '0;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            p_d   = p_sum;
            cnt_d = cnt_q + CW'(1);
        end

        if (finish) begin
            lo_d = p_sum[WIDTH-1:0];
            hi_d = long_q ? p_sum[2*WIDTH-1:WIDTH] : '0;
            if (long_q) begin
                flags_d = {p_sum[2*WIDTH-1], (p_sum == '0), 2'b00};
            end else begin
                flags_d = {p_sum[WIDTH-1], (p_sum[WIDTH-1:0] == '0), 2'b00};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            long_q  <= 1'b0;
            setf_q  <= 1'b0;
            p_q     <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            fw_q    <= 2'b00;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            long_q  <= long_d;
            setf_q  <= setf_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            fw_q    <= fw_d;
        end
    end

    // BusyE is the only combinational output: it must stall the issuing instruction
    // in the very cycle it is presented.
    always_comb begin
        BusyE        = (state_q == RUN) || accept;
        DoneM        = done_q;
        ResultLo     = lo_q;
        ResultHi     = hi_q;
        MulFlags     = flags_q;
        MulFlagWrite = fw_q;
    end

endmodule

// File: tb/tb_mul_unit.sv
// Directed, table-driven bench for mul_unit plus hand-written flush, reset and
// back-to-back sequences.
module tb_mul_unit;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic          clk;
    logic          reset;
    logic          StartE, AccE, LongE, SetFlagsE, FlushE;
    logic [W-1:0]  SrcAE, SrcBE, SrcCE;
    logic          BusyE, DoneM;
    logic [W-1:0]  ResultLo, ResultHi;
    logic [3:0]    MulFlags;
    logic [1:0]    MulFlagWrite;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a, b, c;
        logic         acc, lng, setf;
        logic [W-1:0] lo, hi;
        logic [3:0]   flags;
        logic [1:0]   fw;
    } vec_t;

    vec_t vecs[10];

    mul_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .StartE(StartE), .AccE(AccE), .LongE(LongE), .SetFlagsE(SetFlagsE), .FlushE(FlushE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .SrcCE(SrcCE),
        .BusyE(BusyE), .DoneM(DoneM), .ResultLo(ResultLo), .ResultHi(ResultHi),
        .MulFlags(MulFlags), .MulFlagWrite(MulFlagWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic driveOp(input vec_t v);
        StartE    = 1'b1;
        FlushE    = 1'b0;
        SrcAE     = v.a;
        SrcBE     = v.b;
        SrcCE     = v.c;
        AccE      = v.acc;
        LongE     = v.lng;
        SetFlagsE = v.setf;
    endtask

    // Called just after an edge; returns at the negedge of the DoneM cycle
    // (cycle count relative to the accept edge) or -1 after 40 cycles.
    task automatic waitDone(output int done_cyc, output bit busy_ok);
        done_cyc = -1;
        busy_ok  = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (DoneM) begin
                done_cyc = cyc;
                break;
            end
            if (!BusyE) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int done_cyc, output bit busy_ok);
        bit busy0;
        driveOp(v);
        @(negedge clk);
        busy0 = BusyE;
        @(posedge clk); #1;
        StartE = 1'b0;
        waitDone(done_cyc, busy_ok);
        busy_ok = busy_ok && busy0;
    endtask

    initial begin
        int  dc;
        bit  bok;
        int  dones;
        vec_t v;

        vecs[0] = '{32'd7,        32'd6,        32'd0,        1'b0, 1'b0, 1'b1, 32'd42,       32'd0,        4'b0000, 2'b10};
        vecs[1] = '{32'd0,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b1, 32'd0,        32'd0,        4'b0100, 2'b10};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 2'b10};
        vecs[3] = '{32'd3,        32'd5,        32'd0,        1'b0, 1'b0, 1'b0, 32'd15,       32'd0,        4'b0000, 2'b00};
        vecs[4] = '{32'h00010000, 32'h00010000, 32'd5,        1'b1, 1'b0, 1'b1, 32'd5,        32'd0,        4'b0000, 2'b10};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'd0,        32'hFFFFFFFF, 4'b1000, 2'b10};
        vecs[6] = '{32'h80000000, 32'd1,        32'd0,        1'b0, 1'b0, 1'b1, 32'h80000000, 32'd0,        4'b1000, 2'b10};
        vecs[7] = '{32'h12345678, 32'h00000100, 32'd0,        1'b0, 1'b1, 1'b1, 32'h34567800, 32'h00000012, 4'b0000, 2'b10};
        vecs[8] = '{32'h12345678, 32'h00000100, 32'd0,        1'b0, 1'b0, 1'b0, 32'h34567800, 32'd0,        4'b0000, 2'b00};
        vecs[9] = '{32'd0,        32'd5,        32'd0,        1'b0, 1'b1, 1'b1, 32'd0,        32'd0,        4'b0100, 2'b10};

        reset = 1'b1;
        StartE = 1'b0; AccE = 1'b0; LongE = 1'b0; SetFlagsE = 1'b0; FlushE = 1'b0;
        SrcAE = '0; SrcBE = '0; SrcCE = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", BusyE, 0);
        checkOutput("rst_done", DoneM, 0);
        checkOutput("rst_lo", ResultLo, 0);
        checkOutput("rst_hi", ResultHi, 0);
        checkOutput("rst_flags", MulFlags, 0);
        checkOutput("rst_fw", MulFlagWrite, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], dc, bok);
            checkOutput($sformatf("v%0d_latency", i), dc, LAT);
            checkOutput($sformatf("v%0d_busy", i), bok, 1);
            checkOutput($sformatf("v%0d_lo", i), ResultLo, vecs[i].lo);
            checkOutput($sformatf("v%0d_hi", i), ResultHi, vecs[i].hi);
            checkOutput($sformatf("v%0d_flags", i), MulFlags, vecs[i].flags);
            checkOutput($sformatf("v%0d_fw", i), MulFlagWrite, vecs[i].fw);
            checkOutput($sformatf("v%0d_done_busy", i), BusyE, 0);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_pulse", i), DoneM, 0);
            checkOutput($sformatf("v%0d_fw_clear", i), MulFlagWrite, 0);
            checkOutput($sformatf("v%0d_lo_hold", i), ResultLo, vecs[i].lo);
            @(posedge clk); #1;
        end

        // Flush during cycle 10 of RUN, then a fresh start in cycle 12.
        driveOp(vecs[0]);
        @(posedge clk); #1;
        StartE = 1'b0;
        dones = 0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            FlushE = (cyc == 10);
            @(negedge clk);
            if (DoneM) dones++;
            if (cyc == 10) checkOutput("flush_busy_on", BusyE, 1);
            if (cyc == 11) checkOutput("flush_busy_off", BusyE, 0);
            @(posedge clk); #1;
        end
        FlushE = 1'b0;
        checkOutput("flush_no_done", dones, 0);
        applyStimulus(vecs[3], dc, bok);
        checkOutput("flush_restart_latency", dc, LAT);
        checkOutput("flush_restart_lo", ResultLo, 15);
        @(posedge clk); #1;

        // Back-to-back: op1 3*5 with a stray start in RUN, op2 started in op1's DONE.
        v = '{32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 32'd15, 32'd0, 4'b0000, 2'b10};
        driveOp(v);
        @(posedge clk); #1;
        StartE = 1'b0;
        dones = 0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            StartE = (cyc == 5);
            SrcAE  = (cyc == 5) ? 32'd100 : 32'd3;
            SrcBE  = (cyc == 5) ? 32'd100 : 32'd5;
            AccE   = (cyc == 5);
            SrcCE  = (cyc == 5) ? 32'd9 : 32'd0;
            @(negedge clk);
            if (DoneM) dones++;
            @(posedge clk); #1;
        end
        checkOutput("b2b_no_early_done", dones, 0);
        v = '{32'hFFFFFFFF, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0100, 2'b00};
        driveOp(v);
        @(negedge clk);
        checkOutput("b2b_op1_done", DoneM, 1);
        checkOutput("b2b_op1_lo", ResultLo, 15);
        checkOutput("b2b_op1_fw", MulFlagWrite, 2'b10);
        checkOutput("b2b_op2_busy", BusyE, 1);
        @(posedge clk); #1;
        StartE = 1'b0;
        waitDone(dc, bok);
        checkOutput("b2b_op2_latency", dc, LAT);
        checkOutput("b2b_op2_lo", ResultLo, 0);
        checkOutput("b2b_op2_hi", ResultHi, 0);
        checkOutput("b2b_op2_flags", MulFlags, 4'b0100);
        checkOutput("b2b_op2_fw", MulFlagWrite, 2'b00);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN.
        driveOp(vecs[0]);
        @(posedge clk); #1;
        StartE = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_busy", BusyE, 0);
        checkOutput("arst_done", DoneM, 0);
        checkOutput("arst_lo", ResultLo, 0);
        checkOutput("arst_hi", ResultHi, 0);
        checkOutput("arst_flags", MulFlags, 0);
        checkOutput("arst_fw", MulFlagWrite, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (DoneM) dones++;
        end
        checkOutput("arst_no_done", dones, 0);
        checkOutput("arst_idle_busy", BusyE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative shift-add multiply unit for the pipelined ARM core. It executes MUL, MLA and UMULL-class operations over multiple cycles and produces the result plus NZCV flag updates for the flag registers in the condition logic. It sits alongside the ALU in Execute and holds the pipeline through a busy/stall output until the product is ready. It reuses the FlagWrite encoding: bit 1 updates N,Z and bit 0 updates C,V.

## Interface
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- StartE  in  1  request to start a multiply; sampled when the state is not RUN.
- AccE  in  1  add SrcCE to the product (MLA).
- LongE  in  1  return the full 2*WIDTH product (UMULL); otherwise only the low half is meaningful.
- SetFlagsE  in  1  S bit; the operation updates N and Z.
- FlushE  in  1  abort the operation in progress.
- SrcAE, SrcBE, SrcCE  in  WIDTH each  multiplicand, multiplier, accumulator (all unsigned).
- BusyE  out  1  stall request to the hazard logic.
- DoneM  out  1  one-cycle pulse; the result and flags are valid.
- ResultLo, ResultHi  out  WIDTH each  low and high halves of the product.
- MulFlags  out  4  {N,Z,C,V}.
- MulFlagWrite  out  2  FlagWrite enables qualified by DoneM.

## Operation
- States: IDLE, RUN, DONE. Reset puts the unit in IDLE.
- Accept condition: StartE=1 with the state IDLE or DONE.
- On accept:
  - Capture A, B, LongE and SetFlagsE.
  - Load P (2*WIDTH bits) with {0, SrcCE} if AccE, otherwise 0.
  - Clear the counter i and enter RUN.
- RUN, each cycle: if B[i]=1, then P <= P + (zero-extended A << i). Then i <= i+1.
- The addition wraps at 2*WIDTH bits. Overflow cannot occur for unsigned operands, since (2^W-1)^2 + (2^W-1) < 2^2W.
- RUN exits to DONE after the iteration with i=WIDTH-1.
- DONE lasts one cycle. It returns to IDLE, or goes back to RUN if a new start is accepted in that cycle.
- StartE during RUN is ignored. Upstream must hold the instruction while BusyE=1.
- FlushE=1 in RUN: go to IDLE at the next edge with no DoneM pulse. FlushE has priority over completion.
- FlushE=1 with StartE=1 in the same cycle: the start is not accepted.
- Flags are computed at the exit from RUN:
  - N = P[2W-1] if LongE, else P[W-1].
  - Z = 1 if P is zero (LongE) or P[W-1:0] is zero (not LongE).
  - C = V = 0.
- MulFlagWrite = 2'b10 in the DONE cycle if the captured SetFlagsE=1, otherwise 2'b00. It is 2'b00 outside DONE.
- ResultLo = P[W-1:0]. ResultHi = P[2W-1:W] if LongE, otherwise 0.
- ResultLo, ResultHi and MulFlags hold their value until the next completion.

## Timing
- Reset values: BusyE=0, DoneM=0, ResultLo=0, ResultHi=0, MulFlags=0, MulFlagWrite=0.
- Asserting reset mid-RUN aborts the operation immediately (asynchronous); no DoneM pulse is produced.
- Cycle numbering: accept at edge 0; RUN covers cycles 1..WIDTH; DoneM=1 in cycle WIDTH+1.
- Latency from StartE to DoneM is WIDTH+1 cycles (33 at the default width).
- BusyE is combinational. It is 1 when the state is RUN, or when StartE=1 and FlushE=0 in IDLE/DONE. This stalls the issuing instruction in the same cycle it is presented.
- BusyE=0 in the DONE cycle unless a new start is accepted.
- Back-to-back: a start accepted in the DONE cycle gives its DoneM exactly WIDTH+1 cycles later. The previous results stay valid during that DONE cycle.
- Outputs are registered except BusyE.

## Test plan
- Reset: assert reset mid-RUN -> all outputs 0 immediately, state IDLE, and no DoneM within 40 cycles.
- MUL with flags: A=7, B=6, AccE=0, LongE=0, SetFlagsE=1 -> DoneM at cycle 33, ResultLo=42, ResultHi=0, MulFlags=4'b0000, MulFlagWrite=2'b10. BusyE=1 for cycles 0..32.
- MLA zero result: A=0, B=0xFFFFFFFF, C=0, AccE=1, SetFlagsE=1 -> ResultLo=0, MulFlags=4'b0100.
- UMULL: A=B=0xFFFFFFFF, LongE=1, SetFlagsE=1 -> ResultHi=0xFFFFFFFE, ResultLo=0x00000001, N=1, Z=0.
- Flush: FlushE=1 at cycle 10 of RUN -> no DoneM, and BusyE=0 from cycle 11. A new start at cycle 12 completes normally at cycle 45.
- Back-to-back with MLA wrap: start op1 (3*5); StartE held in its DONE cycle for op2 (A=0xFFFFFFFF, B=1, C=1, AccE=1, LongE=0, SetFlagsE=0) -> op1 ResultLo=15, then op2 ResultLo=0 exactly 33 cycles later with MulFlagWrite=2'b00. A StartE pulse during op1's RUN is ignored.
